// File: rtl/velocity_pkg.sv
// rtl/velocity_pkg.sv - shared types and helpers for the velocity write scheduler
//   VEL_W         : velocity word width
//   vel_t         : signed velocity word
//   sched_state_t : shot life-cycle states, listed in cycle order
//   clamp_vel     : symmetric saturation of one velocity axis
package velocity_pkg;

    localparam int VEL_W = 11;

    typedef logic signed [VEL_W-1:0] vel_t;

    typedef enum logic [1:0] {
        SETTLE  = 2'd0,
        READY   = 2'd1,
        SHOT    = 2'd2,
        ROLLING = 2'd3
    } sched_state_t;

    // lim is a non-negative magnitude; each axis is limited to [-lim, +lim].
    function automatic vel_t clamp_vel(input vel_t v, input vel_t lim);
        if (v > lim) begin
            return lim;
        end else if (v < -lim) begin
            return -lim;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/velocity_write_scheduler_if.sv
// rtl/velocity_write_scheduler_if.sv - request, motion and write-port bundle of the scheduler
//   startOfFrame, ballMoving       : frame pulse and per-ball motion flags
//   hitReq/hitBallId/hitVelX/Y     : collision update request, hitAck grant
//   lineReq/lineVelX/Y             : cue shot request, lineAck grant
//   outBallId/outVelocityX/Y       : registered velocity write port, WriteEnable strobe
//   shotInProgress                 : high while the table is not ready for a shot
//   modports: master (requester/environment side), slave (scheduler side)
interface velocity_write_scheduler_if #(
    parameter int NUM_BALLS = 16,
    parameter int BALL_ID_W = 4
);
    import velocity_pkg::*;

    logic                 startOfFrame;
    logic [NUM_BALLS-1:0] ballMoving;

    logic                 hitReq;
    logic [BALL_ID_W-1:0] hitBallId;
    vel_t                 hitVelX;
    vel_t                 hitVelY;
    logic                 hitAck;

    logic                 lineReq;
    vel_t                 lineVelX;
    vel_t                 lineVelY;
    logic                 lineAck;

    logic [BALL_ID_W-1:0] outBallId;
    vel_t                 outVelocityX;
    vel_t                 outVelocityY;
    logic                 WriteEnable;
    logic                 shotInProgress;

    modport master (
        output startOfFrame, ballMoving,
        output hitReq, hitBallId, hitVelX, hitVelY,
        output lineReq, lineVelX, lineVelY,
        input  hitAck, lineAck,
        input  outBallId, outVelocityX, outVelocityY, WriteEnable, shotInProgress
    );

    modport slave (
        input  startOfFrame, ballMoving,
        input  hitReq, hitBallId, hitVelX, hitVelY,
        input  lineReq, lineVelX, lineVelY,
        output hitAck, lineAck,
        output outBallId, outVelocityX, outVelocityY, WriteEnable, shotInProgress
    );

endinterface

// File: rtl/rest_frame_counter.sv
// rtl/rest_frame_counter.sv - saturating frame counter with clear and terminal detect
//   clk, rst : clock, synchronous active-high reset
//   clear    : reload to zero (wins over inc)
//   inc      : count one frame this cycle
//   done     : this increment reaches TERMINAL frames
module rest_frame_counter #(
    parameter int WIDTH    = 8,
    parameter int TERMINAL = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic done
);

    localparam logic [WIDTH-1:0] TERM = WIDTH'(TERMINAL);
    localparam logic [WIDTH-1:0] LAST = WIDTH'(TERMINAL - 1);

    logic [WIDTH-1:0] count;

    // Flagged on the incrementing cycle so the owner can change state on the
    // same edge the terminal count is reached.
    assign done = inc && (count >= LAST);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (inc && (count != TERM)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/velocity_write_scheduler.sv
// rtl/velocity_write_scheduler.sv - arbitrates hit and cue-shot writes into ball velocity registers
//   clk, rst : clock, synchronous active-high reset
//   bus      : velocity_write_scheduler_if.slave (requests, motion flags, write port)
module velocity_write_scheduler
    import velocity_pkg::*;
#(
    parameter int NUM_BALLS        = 16,
    parameter int BALL_ID_W        = 4,
    parameter int STOP_FRAMES      = 8,
    parameter int SHOT_WAIT_FRAMES = 2,
    parameter int MAX_SHOT_SPEED   = 400
) (
    input logic                     clk,
    input logic                     rst,
    velocity_write_scheduler_if.slave bus
);

    typedef logic [BALL_ID_W-1:0] ball_id_t;

    localparam vel_t SHOT_LIM = vel_t'(MAX_SHOT_SPEED);

    sched_state_t state;
    sched_state_t state_next;

    logic     any_moving;
    logic     hit_ack;
    logic     line_ack;
    logic     hit_valid;

    logic     stop_inc;
    logic     stop_clear;
    logic     stop_done;
    logic     wait_inc;
    logic     wait_clear;
    logic     wait_done;

    logic     wr_en_next;
    ball_id_t wr_id_next;
    vel_t     wr_vx_next;
    vel_t     wr_vy_next;

    logic     wr_en_q;
    ball_id_t wr_id_q;
    vel_t     wr_vx_q;
    vel_t     wr_vy_q;
    logic     shot_q;

    assign any_moving = |bus.ballMoving;

    // Hits are always granted; a shot only from READY and only when no hit
    // competes. Nothing is granted while reset is held.
    assign hit_ack   = bus.hitReq && !rst;
    assign line_ack  = bus.lineReq && !bus.hitReq && (state == READY) && !rst;
    assign hit_valid = int'(bus.hitBallId) < NUM_BALLS;

    assign bus.hitAck  = hit_ack;
    assign bus.lineAck = line_ack;

    // Each counter runs only in its own state and is reloaded on any
    // transition, so a frame pulse coincident with a transition is not counted.
    assign stop_inc   = bus.startOfFrame && (state == SETTLE) && !any_moving;
    assign stop_clear = (state != SETTLE) || (state_next != SETTLE);
    assign wait_inc   = bus.startOfFrame && (state == SHOT) && !any_moving;
    assign wait_clear = (state != SHOT) || (state_next != SHOT);

    rest_frame_counter #(
        .WIDTH    (8),
        .TERMINAL (STOP_FRAMES)
    ) u_stop_counter (
        .clk   (clk),
        .rst   (rst),
        .clear (stop_clear),
        .inc   (stop_inc),
        .done  (stop_done)
    );

    rest_frame_counter #(
        .WIDTH    (4),
        .TERMINAL (SHOT_WAIT_FRAMES)
    ) u_wait_counter (
        .clk   (clk),
        .rst   (rst),
        .clear (wait_clear),
        .inc   (wait_inc),
        .done  (wait_done)
    );

    always_comb begin
        state_next = state;
        case (state)
            SETTLE: begin
                if (any_moving) begin
                    state_next = ROLLING;
                end else if (stop_done) begin
                    state_next = READY;
                end
            end
            READY: begin
                // A granted shot wins over motion seen in the same cycle.
                if (line_ack) begin
                    state_next = SHOT;
                end else if (any_moving) begin
                    state_next = ROLLING;
                end
            end
            SHOT: begin
                if (any_moving) begin
                    state_next = ROLLING;
                end else if (wait_done) begin
                    state_next = SETTLE;
                end
            end
            ROLLING: begin
                if (!any_moving) begin
                    state_next = SETTLE;
                end
            end
            default: state_next = SETTLE;
        endcase
    end

    always_comb begin
        wr_en_next = 1'b0;
        wr_id_next = '0;
        wr_vx_next = '0;
        wr_vy_next = '0;
        if (hit_ack) begin
            // Out-of-range ids are acknowledged and dropped.
            if (hit_valid) begin
                wr_en_next = 1'b1;
                wr_id_next = bus.hitBallId;
                wr_vx_next = bus.hitVelX;
                wr_vy_next = bus.hitVelY;
            end
        end else if (line_ack) begin
            wr_en_next = 1'b1;
            wr_id_next = '0;
            wr_vx_next = clamp_vel(bus.lineVelX, SHOT_LIM);
            wr_vy_next = clamp_vel(bus.lineVelY, SHOT_LIM);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= SETTLE;
            shot_q  <= 1'b0;
            wr_en_q <= 1'b0;
            wr_id_q <= '0;
            wr_vx_q <= '0;
            wr_vy_q <= '0;
        end else begin
            state   <= state_next;
            // Taken from the next state so the flag rises with the shot itself.
            shot_q  <= (state_next != READY);
            wr_en_q <= wr_en_next;
            wr_id_q <= wr_id_next;
            wr_vx_q <= wr_vx_next;
            wr_vy_q <= wr_vy_next;
        end
    end

    // A write already registered when reset arrives is withheld from the
    // port, so the reset cycle never carries a write.
    assign bus.WriteEnable    = wr_en_q && !rst;
    assign bus.outBallId      = rst ? '0 : wr_id_q;
    assign bus.outVelocityX   = rst ? '0 : wr_vx_q;
    assign bus.outVelocityY   = rst ? '0 : wr_vy_q;
    assign bus.shotInProgress = shot_q && !rst;

endmodule

// File: tb/tb_velocity_write_scheduler.sv
// tb/tb_velocity_write_scheduler.sv - directed table-driven bench for velocity_write_scheduler
module tb_velocity_write_scheduler;
    import velocity_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    velocity_write_scheduler_if #(.NUM_BALLS(16), .BALL_ID_W(5)) bus();

    velocity_write_scheduler #(
        .NUM_BALLS        (16),
        .BALL_ID_W        (5),
        .STOP_FRAMES      (8),
        .SHOT_WAIT_FRAMES (2),
        .MAX_SHOT_SPEED   (400)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       nm;
        bit          sof;
        logic [15:0] mv;
        bit          hreq;
        int          hid;
        int          hvx;
        int          hvy;
        bit          lreq;
        int          lvx;
        int          lvy;
        bit          e_hack;
        bit          e_lack;
        bit          e_we;
        int          e_id;
        int          e_vx;
        int          e_vy;
        bit          e_shot;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic add(input string nm, input bit sof, input logic [15:0] mv,
                       input bit hreq, input int hid, input int hvx, input int hvy,
                       input bit lreq, input int lvx, input int lvy,
                       input bit e_hack, input bit e_lack, input bit e_we,
                       input int e_id, input int e_vx, input int e_vy, input bit e_shot);
        vec_t v;
        v.nm = nm; v.sof = sof; v.mv = mv;
        v.hreq = hreq; v.hid = hid; v.hvx = hvx; v.hvy = hvy;
        v.lreq = lreq; v.lvx = lvx; v.lvy = lvy;
        v.e_hack = e_hack; v.e_lack = e_lack; v.e_we = e_we;
        v.e_id = e_id; v.e_vx = e_vx; v.e_vy = e_vy; v.e_shot = e_shot;
        vecs.push_back(v);
    endtask

    task automatic drive(input bit sof, input logic [15:0] mv,
                         input bit hreq, input int hid, input int hvx, input int hvy,
                         input bit lreq, input int lvx, input int lvy);
        bus.startOfFrame = sof;
        bus.ballMoving   = mv;
        bus.hitReq       = hreq;
        bus.hitBallId    = 5'(hid);
        bus.hitVelX      = vel_t'(hvx);
        bus.hitVelY      = vel_t'(hvy);
        bus.lineReq      = lreq;
        bus.lineVelX     = vel_t'(lvx);
        bus.lineVelY     = vel_t'(lvy);
    endtask

    task automatic check_port(input string nm, input bit we, input int id,
                              input int vx, input int vy, input bit shot);
        chk({nm, ".WriteEnable"},    int'(bus.WriteEnable), int'(we));
        chk({nm, ".outBallId"},      int'(bus.outBallId), id);
        chk({nm, ".outVelocityX"},   int'(bus.outVelocityX), vx);
        chk({nm, ".outVelocityY"},   int'(bus.outVelocityY), vy);
        chk({nm, ".shotInProgress"}, int'(bus.shotInProgress), int'(shot));
    endtask

    task automatic quiet_frames(input int n);
        for (int k = 0; k < n; k++) begin
            drive(1, 16'h0, 0, 0, 0, 0, 0, 0, 0);
            @(posedge clk);
            #1;
        end
        drive(0, 16'h0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset to READY over 8 frames, first shot written a cycle after its ack.
        for (int i = 0; i < 7; i++)
            add($sformatf("settle%0d", i), 1, 16'h0, 0,0,0,0, 0,0,0, 0,0,0,0,0,0, 1);
        add("settle_to_ready", 1, 16'h0, 0,0,0,0, 0,0,0,        0,0,0,0,0,0, 0);
        add("line_first",      0, 16'h0, 0,0,0,0, 1,120,-50,    0,1,1,0,120,-50, 1);
        add("shot_motion",     0, 16'h4, 0,0,0,0, 0,0,0,        0,0,0,0,0,0, 1);
        // Shot request stalls through ROLLING and the following 8 quiet frames.
        add("line_rolling",    0, 16'h4, 0,0,0,0, 1,900,-1000,  0,0,0,0,0,0, 1);
        add("rolling_stop",    0, 16'h0, 0,0,0,0, 1,900,-1000,  0,0,0,0,0,0, 1);
        for (int i = 0; i < 7; i++)
            add($sformatf("quiet%0d", i), 1, 16'h0, 0,0,0,0, 1,900,-1000, 0,0,0,0,0,0, 1);
        add("quiet_last",      1, 16'h0, 0,0,0,0, 1,900,-1000,  0,0,0,0,0,0, 0);
        add("line_clamp",      0, 16'h0, 0,0,0,0, 1,900,-1000,  0,1,1,0,400,-400, 1);
        // No motion after the shot: two frames back to SETTLE, then 8 more.
        add("hit_in_shot",     1, 16'h0, 1,5,-7,300, 0,0,0,     1,0,1,5,-7,300, 1);
        add("shot_wait_done",  1, 16'h0, 0,0,0,0, 0,0,0,        0,0,0,0,0,0, 1);
        for (int i = 0; i < 7; i++)
            add($sformatf("resettle%0d", i), 1, 16'h0, 0,0,0,0, 0,0,0, 0,0,0,0,0,0, 1);
        add("resettle_last",   1, 16'h0, 0,0,0,0, 0,0,0,        0,0,0,0,0,0, 0);
        add("hit_beats_line",  0, 16'h0, 1,3,10,20, 1,0,0,      1,0,1,3,10,20, 0);
        add("line_zero",       0, 16'h0, 0,0,0,0, 1,0,0,        0,1,1,0,0,0, 1);
        // Hit id range edges.
        add("hit_id17",        0, 16'h8000, 1,17,-3,4, 0,0,0,   1,0,0,0,0,0, 1);
        add("hit_id15",        0, 16'h8000, 1,15,-1024,1023, 0,0,0, 1,0,1,15,-1024,1023, 1);
        add("hit_id16",        0, 16'h0, 1,16,5,5, 0,0,0,       1,0,0,0,0,0, 1);
        // Motion mid-count restarts the rest count from zero.
        for (int i = 0; i < 4; i++)
            add($sformatf("partial%0d", i), 1, 16'h0, 0,0,0,0, 0,0,0, 0,0,0,0,0,0, 1);
        add("sof_and_motion",  1, 16'h1, 0,0,0,0, 0,0,0,        0,0,0,0,0,0, 1);
        add("motion_gone",     0, 16'h0, 0,0,0,0, 0,0,0,        0,0,0,0,0,0, 1);
        for (int i = 0; i < 7; i++)
            add($sformatf("recount%0d", i), 1, 16'h0, 0,0,0,0, 1,-401,400, 0,0,0,0,0,0, 1);
        add("recount_last",    1, 16'h0, 0,0,0,0, 1,-401,400,   0,0,0,0,0,0, 0);
        add("line_clamp_edge", 0, 16'h0, 0,0,0,0, 1,-401,400,   0,1,1,0,-400,400, 1);

        // Reset state, with requests pending to show nothing is granted.
        rst = 1'b1;
        drive(0, 16'h0, 1, 2, 1, 1, 1, 5, 5);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset.hitAck",  int'(bus.hitAck), 0);
        chk("reset.lineAck", int'(bus.lineAck), 0);
        check_port("reset", 0, 0, 0, 0, 0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].sof, vecs[i].mv, vecs[i].hreq, vecs[i].hid, vecs[i].hvx,
                  vecs[i].hvy, vecs[i].lreq, vecs[i].lvx, vecs[i].lvy);
            #1;
            chk({vecs[i].nm, ".hitAck"},  int'(bus.hitAck),  int'(vecs[i].e_hack));
            chk({vecs[i].nm, ".lineAck"}, int'(bus.lineAck), int'(vecs[i].e_lack));
            @(posedge clk);
            #1;
            check_port(vecs[i].nm, vecs[i].e_we, vecs[i].e_id, vecs[i].e_vx,
                       vecs[i].e_vy, vecs[i].e_shot);
        end

        // Reset the cycle after a line ack: the pending write never appears.
        drive(0, 16'h0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        quiet_frames(8);
        chk("ready_again.shotInProgress", int'(bus.shotInProgress), 0);
        drive(0, 16'h0, 0, 0, 0, 0, 1, 50, 60);
        #1;
        chk("rst_seq.lineAck", int'(bus.lineAck), 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(0, 16'h0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check_port("rst_after_ack", 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(0, 16'h0, 0, 0, 0, 0, 1, 50, 60);
        #1;
        chk("post_rst.lineAck", int'(bus.lineAck), 0);
        check_port("post_rst", 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        check_port("post_rst_settle", 0, 0, 0, 0, 1);

        // Reset coinciding with the grant cycle in READY: grant discarded.
        drive(0, 16'h0, 0, 0, 0, 0, 0, 0, 0);
        quiet_frames(8);
        chk("ready_third.shotInProgress", int'(bus.shotInProgress), 0);
        rst = 1'b1;
        drive(0, 16'h0, 1, 4, 9, 9, 1, 70, 80);
        #1;
        chk("rst_grant.hitAck",  int'(bus.hitAck), 0);
        chk("rst_grant.lineAck", int'(bus.lineAck), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(0, 16'h0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check_port("rst_grant_after", 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
